// File: rtl/jtag_tap_ctrl_if.sv
// Bundle of the TAP controller's TMS input and its state/decode outputs.
// The master modport belongs to whoever drives TMS; the slave modport belongs to the controller.
interface jtag_tap_ctrl_if;
    logic       i_tms;
    logic [3:0] o_state;
    logic       o_stateIsTestLogicReset;
    logic       o_stateIsRunTestIdle;
    logic       o_stateIsCaptureIr;
    logic       o_stateIsShiftIr;
    logic       o_stateIsUpdateIr;
    logic       o_stateIsCaptureDr;
    logic       o_stateIsShiftDr;
    logic       o_stateIsUpdateDr;
    logic       o_stateIsPauseDr;
    logic       o_stateIsPauseIr;

    modport master (
        output i_tms,
        input  o_state, o_stateIsTestLogicReset, o_stateIsRunTestIdle,
               o_stateIsCaptureIr, o_stateIsShiftIr, o_stateIsUpdateIr,
               o_stateIsCaptureDr, o_stateIsShiftDr, o_stateIsUpdateDr,
               o_stateIsPauseDr, o_stateIsPauseIr
    );

    modport slave (
        input  i_tms,
        output o_state, o_stateIsTestLogicReset, o_stateIsRunTestIdle,
               o_stateIsCaptureIr, o_stateIsShiftIr, o_stateIsUpdateIr,
               o_stateIsCaptureDr, o_stateIsShiftDr, o_stateIsUpdateDr,
               o_stateIsPauseDr, o_stateIsPauseIr
    );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: a 16-state FSM clocked by TCK and steered by TMS.
// Every 4-bit code is a legal state, and the decode outputs are Moore functions of the state register.
module jtag_tap_ctrl (
    input  logic            i_tclk,
    input  logic            i_trst_n,
    jtag_tap_ctrl_if.slave  tap
);

    typedef enum logic [3:0] {
        ST_EX2DR  = 4'h0,
        ST_EX1DR  = 4'h1,
        ST_SHDR   = 4'h2,
        ST_PAUDR  = 4'h3,
        ST_SELIR  = 4'h4,
        ST_UPDDR  = 4'h5,
        ST_CAPDR  = 4'h6,
        ST_SELDR  = 4'h7,
        ST_EX2IR  = 4'h8,
        ST_EX1IR  = 4'h9,
        ST_SHIR   = 4'hA,
        ST_PAUIR  = 4'hB,
        ST_RTI    = 4'hC,
        ST_UPDIR  = 4'hD,
        ST_CAPIR  = 4'hE,
        ST_TLR    = 4'hF
    } tap_state_e;

    tap_state_e state_q;

    // TAP state register and transition arcs; TRST forces Test-Logic-Reset without waiting for TCK
    always_ff @(posedge i_tclk or negedge i_trst_n) begin
        if (!i_trst_n) begin
            state_q <= ST_TLR;
        end else begin
            case (state_q)
                ST_TLR:   state_q <= tap.i_tms ? ST_TLR   : ST_RTI;
                ST_RTI:   state_q <= tap.i_tms ? ST_SELDR : ST_RTI;
                ST_SELDR: state_q <= tap.i_tms ? ST_SELIR : ST_CAPDR;
                ST_SELIR: state_q <= tap.i_tms ? ST_TLR   : ST_CAPIR;
                ST_CAPDR: state_q <= tap.i_tms ? ST_EX1DR : ST_SHDR;
                ST_SHDR:  state_q <= tap.i_tms ? ST_EX1DR : ST_SHDR;
                ST_EX1DR: state_q <= tap.i_tms ? ST_UPDDR : ST_PAUDR;
                ST_PAUDR: state_q <= tap.i_tms ? ST_EX2DR : ST_PAUDR;
                ST_EX2DR: state_q <= tap.i_tms ? ST_UPDDR : ST_SHDR;
                ST_UPDDR: state_q <= tap.i_tms ? ST_SELDR : ST_RTI;
                ST_CAPIR: state_q <= tap.i_tms ? ST_EX1IR : ST_SHIR;
                ST_SHIR:  state_q <= tap.i_tms ? ST_EX1IR : ST_SHIR;
                ST_EX1IR: state_q <= tap.i_tms ? ST_UPDIR : ST_PAUIR;
                ST_PAUIR: state_q <= tap.i_tms ? ST_EX2IR : ST_PAUIR;
                ST_EX2IR: state_q <= tap.i_tms ? ST_UPDIR : ST_SHIR;
                ST_UPDIR: state_q <= tap.i_tms ? ST_SELDR : ST_RTI;
                default:  state_q <= ST_TLR;
            endcase
        end
    end

    // Decodes come straight off the state flops, so they never depend on TMS
    assign tap.o_state                 = state_q;
    assign tap.o_stateIsTestLogicReset = (state_q == ST_TLR);
    assign tap.o_stateIsRunTestIdle    = (state_q == ST_RTI);
    assign tap.o_stateIsCaptureIr      = (state_q == ST_CAPIR);
    assign tap.o_stateIsShiftIr        = (state_q == ST_SHIR);
    assign tap.o_stateIsUpdateIr       = (state_q == ST_UPDIR);
    assign tap.o_stateIsCaptureDr      = (state_q == ST_CAPDR);
    assign tap.o_stateIsShiftDr        = (state_q == ST_SHDR);
    assign tap.o_stateIsUpdateDr       = (state_q == ST_UPDDR);
    assign tap.o_stateIsPauseDr        = (state_q == ST_PAUDR);
    assign tap.o_stateIsPauseIr        = (state_q == ST_PAUIR);

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed testbench for jtag_tap_ctrl: reset, IR/DR scans, TMS reset, async reset and all 32 arcs.
module tb_jtag_tap_ctrl;

    logic tclk;
    logic trst_n;
    int   checks;
    int   errors;

    jtag_tap_ctrl_if tap_if ();

    jtag_tap_ctrl dut (
        .i_tclk   (tclk),
        .i_trst_n (trst_n),
        .tap      (tap_if.slave)
    );

    // Hand-written arc table: bits [7:4] give the next state for TMS=1, bits [3:0] for TMS=0
    function automatic logic [7:0] arcs(input logic [3:0] s);
        case (s)
            4'hF: arcs = 8'hFC;
            4'hC: arcs = 8'h7C;
            4'h7: arcs = 8'h46;
            4'h4: arcs = 8'hFE;
            4'h6: arcs = 8'h12;
            4'h2: arcs = 8'h12;
            4'h1: arcs = 8'h53;
            4'h3: arcs = 8'h03;
            4'h0: arcs = 8'h52;
            4'h5: arcs = 8'h7C;
            4'hE: arcs = 8'h9A;
            4'hA: arcs = 8'h9A;
            4'h9: arcs = 8'hDB;
            4'hB: arcs = 8'h8B;
            4'h8: arcs = 8'hDA;
            4'hD: arcs = 8'h7C;
            default: arcs = 8'h00;
        endcase
    endfunction

    // Expected decodes {TLR,RTI,CapIR,ShIR,UpdIR,CapDR,ShDR,UpdDR,PauDR,PauIR}
    function automatic logic [9:0] dec_exp(input logic [3:0] s);
        case (s)
            4'hF: dec_exp = 10'b10_0000_0000;
            4'hC: dec_exp = 10'b01_0000_0000;
            4'hE: dec_exp = 10'b00_1000_0000;
            4'hA: dec_exp = 10'b00_0100_0000;
            4'hD: dec_exp = 10'b00_0010_0000;
            4'h6: dec_exp = 10'b00_0001_0000;
            4'h2: dec_exp = 10'b00_0000_1000;
            4'h5: dec_exp = 10'b00_0000_0100;
            4'h3: dec_exp = 10'b00_0000_0010;
            4'hB: dec_exp = 10'b00_0000_0001;
            default: dec_exp = 10'b00_0000_0000;
        endcase
    endfunction

    // TMS paths from TLR to each state, applied LSB first
    function automatic int path_len(input logic [3:0] s);
        case (s)
            4'hF: path_len = 0;
            4'hC: path_len = 1;
            4'h7: path_len = 2;
            4'h4: path_len = 3;
            4'h6: path_len = 3;
            4'hE: path_len = 4;
            4'h2: path_len = 4;
            4'h1: path_len = 4;
            4'hA: path_len = 5;
            4'h9: path_len = 5;
            4'h3: path_len = 5;
            4'h5: path_len = 5;
            4'h0: path_len = 6;
            4'hB: path_len = 6;
            4'hD: path_len = 6;
            4'h8: path_len = 7;
            default: path_len = 0;
        endcase
    endfunction

    function automatic logic [7:0] path_bits(input logic [3:0] s);
        case (s)
            4'hC: path_bits = 8'b0000_0000;
            4'h7: path_bits = 8'b0000_0010;
            4'h4: path_bits = 8'b0000_0110;
            4'h6: path_bits = 8'b0000_0010;
            4'hE: path_bits = 8'b0000_0110;
            4'h2: path_bits = 8'b0000_0010;
            4'h1: path_bits = 8'b0000_1010;
            4'hA: path_bits = 8'b0000_0110;
            4'h9: path_bits = 8'b0001_0110;
            4'h3: path_bits = 8'b0000_1010;
            4'h5: path_bits = 8'b0001_1010;
            4'h0: path_bits = 8'b0010_1010;
            4'hB: path_bits = 8'b0001_0110;
            4'hD: path_bits = 8'b0011_0110;
            4'h8: path_bits = 8'b0101_0110;
            default: path_bits = 8'b0000_0000;
        endcase
    endfunction

    function automatic logic [9:0] dec_obs();
        dec_obs = {tap_if.o_stateIsTestLogicReset, tap_if.o_stateIsRunTestIdle,
                   tap_if.o_stateIsCaptureIr, tap_if.o_stateIsShiftIr,
                   tap_if.o_stateIsUpdateIr, tap_if.o_stateIsCaptureDr,
                   tap_if.o_stateIsShiftDr, tap_if.o_stateIsUpdateDr,
                   tap_if.o_stateIsPauseDr, tap_if.o_stateIsPauseIr};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One TCK cycle: TMS set while TCK is low; outputs are sampled 5 time units after the rising edge
    task automatic step(input logic tms);
        tap_if.i_tms = tms;
        #5 tclk = 1'b1;
        #5 tclk = 1'b0;
    endtask

    task automatic pulse_reset();
        trst_n = 1'b0;
        #2 trst_n = 1'b1;
        #2;
    endtask

    task automatic goto_state(input logic [3:0] s);
        logic [7:0] bits;
        bits = path_bits(s);
        pulse_reset();
        for (int k = 0; k < path_len(s); k++) step(bits[k]);
    endtask

    logic [3:0] ir_exp [10];
    logic [9:0] ir_tms;
    logic [3:0] dr_exp [11];
    logic [10:0] dr_tms;
    int         cnt_a;
    int         cnt_b;
    logic [7:0] arc;

    initial begin
        checks = 0;
        errors = 0;
        tclk = 1'b0;
        tap_if.i_tms = 1'b1;
        trst_n = 1'b1;
        #3;

        // Reset with TCK idle
        trst_n = 1'b0;
        #4;
        check("reset_state", {12'h000, tap_if.o_state}, 16'h000F);
        check("reset_dec", {6'h00, dec_obs()}, {6'h00, 10'b10_0000_0000});
        trst_n = 1'b1;
        #3;
        check("reset_hold", {12'h000, tap_if.o_state}, 16'h000F);

        // IR scan from TLR
        ir_exp = '{4'hC, 4'h7, 4'h4, 4'hE, 4'hA, 4'hA, 4'hA, 4'h9, 4'hD, 4'hC};
        ir_tms = 10'b01_1000_0110;
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 10; i++) begin
            step(ir_tms[i]);
            check($sformatf("ir_scan_%0d", i), {12'h000, tap_if.o_state}, {12'h000, ir_exp[i]});
            if (tap_if.o_stateIsShiftIr === 1'b1) cnt_a++;
            if (tap_if.o_stateIsUpdateIr === 1'b1) cnt_b++;
        end
        check("ir_shift_cycles", cnt_a[15:0], 16'd3);
        check("ir_update_cycles", cnt_b[15:0], 16'd1);

        // DR scan with pause from RTI
        dr_exp = '{4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h3, 4'h0, 4'h2, 4'h1, 4'h5, 4'hC};
        dr_tms = 11'b011_0100_1001;
        cnt_a = 0;
        for (int i = 0; i < 11; i++) begin
            step(dr_tms[i]);
            check($sformatf("dr_scan_%0d", i), {12'h000, tap_if.o_state}, {12'h000, dr_exp[i]});
            if (tap_if.o_stateIsPauseDr === 1'b1) cnt_a++;
        end
        check("dr_pause_cycles", cnt_a[15:0], 16'd2);

        // Every state: decodes, both arcs, and five-TMS=1 return to TLR
        for (int s = 0; s < 16; s++) begin
            arc = arcs(s[3:0]);
            for (int b = 0; b < 2; b++) begin
                goto_state(s[3:0]);
                check($sformatf("reach_%0h", s), {12'h000, tap_if.o_state}, {12'h000, s[3:0]});
                check($sformatf("dec_%0h", s), {6'h00, dec_obs()}, {6'h00, dec_exp(s[3:0])});
                step(b[0]);
                check($sformatf("arc_%0h_tms%0d", s, b), {12'h000, tap_if.o_state},
                      {12'h000, (b == 1) ? arc[7:4] : arc[3:0]});
            end
            goto_state(s[3:0]);
            for (int k = 0; k < 5; k++) step(1'b1);
            check($sformatf("tms_reset_%0h", s), {12'h000, tap_if.o_state}, 16'h000F);
        end
        step(1'b1);
        check("tlr_hold", {12'h000, tap_if.o_state}, 16'h000F);

        // Async reset while shifting IR, between edges
        goto_state(4'hA);
        step(1'b0);
        check("pre_async_shir", {12'h000, tap_if.o_state}, 16'h000A);
        tap_if.i_tms = 1'b1;
        #2 trst_n = 1'b0;
        #1;
        check("async_state", {12'h000, tap_if.o_state}, 16'h000F);
        check("async_shir", {15'h0000, tap_if.o_stateIsShiftIr}, 16'h0000);
        check("async_updir", {15'h0000, tap_if.o_stateIsUpdateIr}, 16'h0000);
        check("async_dec", {6'h00, dec_obs()}, {6'h00, 10'b10_0000_0000});
        #2 tclk = 1'b1;
        #5 tclk = 1'b0;
        check("async_no_updir", {15'h0000, tap_if.o_stateIsUpdateIr}, 16'h0000);
        check("async_clk_ignored", {12'h000, tap_if.o_state}, 16'h000F);
        trst_n = 1'b1;
        #2;
        step(1'b0);
        check("post_reset_rti", {12'h000, tap_if.o_state}, 16'h000C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ctrl.md
JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 Parameters: none; the state width is fixed at 4 bits.
REQ-002 i_tclk  input  1  TAP clock; all state updates on rising edge.
REQ-003 i_trst_n  input  1  asynchronous, active-low TAP reset.
REQ-004 i_tms  input  1  test mode select, sampled on rising i_tclk.
REQ-005 o_state  output  4  current TAP state, encoded per REQ-008.
REQ-006 o_stateIsTestLogicReset, o_stateIsRunTestIdle  output  1 each  state decodes.
REQ-007 o_stateIsCaptureIr, o_stateIsShiftIr, o_stateIsUpdateIr, o_stateIsCaptureDr, o_stateIsShiftDr, o_stateIsUpdateDr, o_stateIsPauseDr, o_stateIsPauseIr  output  1 each  state decodes; o_stateIsUpdateIr drives the instruction-register load enable.

Function
REQ-008 State encoding (IEEE 1149.1):
- TLR=F, RTI=C.
- SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5.
- SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D.
REQ-009 The state register SHALL be a single 4-bit register updated only on rising i_tclk when i_trst_n=1.
REQ-010 Next-state logic, written as TMS=0 / TMS=1:
- TLR: RTI / TLR.
- RTI: RTI / SelDR.
- SelDR: CapDR / SelIR.
- SelIR: CapIR / TLR.
REQ-011 The DR column SHALL transition as follows (TMS=0 / TMS=1):
- CapDR: ShDR / Ex1DR.
- ShDR: ShDR / Ex1DR.
- Ex1DR: PauDR / UpdDR.
- PauDR: PauDR / Ex2DR.
- Ex2DR: ShDR / UpdDR.
- UpdDR: RTI / SelDR.
REQ-012 The IR column SHALL mirror REQ-011 exactly, with IR substituted for DR in every state.
REQ-013 All o_stateIs* outputs SHALL be pure combinational decodes of the state register (Moore); each is 1 exactly when o_state equals its state, and no output depends on i_tms.
REQ-014 Exactly one of the ten decode outputs SHALL be high when the state is TLR, RTI, Cap*, Sh*, Upd* or Pau*; all ten SHALL be 0 in Sel*, Ex1* and Ex2* states.
REQ-015 Five consecutive rising edges with i_tms=1 SHALL reach TLR from any state; TLR with i_tms=1 SHALL hold in TLR.
REQ-016 o_stateIsUpdateIr SHALL be high for exactly one i_tclk cycle per UpdIR visit, because UpdIR always exits on the next edge.
REQ-017 The 4-bit state register has no unreachable or illegal encodings, since all 16 codes are states; no recovery logic is required.

Reset
REQ-018 Assertion of i_trst_n=0 SHALL force the state to TLR (F) immediately, independent of i_tclk, including mid-shift.
REQ-019 During and after reset: o_stateIsTestLogicReset=1 and every other o_stateIs* output=0.
REQ-020 On the first rising i_tclk after i_trst_n deasserts, the state SHALL advance per REQ-010 from TLR.

Verification
REQ-021 Reset: pulse i_trst_n low with i_tclk idle -> o_state=F, o_stateIsTestLogicReset=1, all other decodes 0.
REQ-022 IR scan: from TLR apply TMS 0,1,1,0,0,0,0,1,1,0 -> states:
- C, 7, 4, E, A, A, A, 9, D, C.
- o_stateIsShiftIr high for 3 cycles.
- o_stateIsUpdateIr high for 1 cycle.
REQ-023 DR scan with pause: from RTI apply TMS 1,0,0,1,0,0,1,0,1,1,0 -> states:
- 7, 6, 2, 1, 3, 3, 0, 2, 1, 5, C.
- o_stateIsPauseDr high for 2 cycles.
REQ-024 TMS-reset: from each of the 16 states, apply 5 edges with TMS=1 -> o_state=F after the fifth edge, every case.
REQ-025 Async reset mid-operation: in ShIR (A), drop i_trst_n between clock edges -> o_state=F before the next i_tclk edge, o_stateIsShiftIr=0, and no UpdIR pulse.
REQ-026 Exhaustive transition check: for every state and both TMS values, compare the next state with REQ-010 to REQ-012 -> all 32 arcs match.
